// File: rtl/box_rom_arbiter_pkg.sv
// Shared sprite constants, texel address payload and the box sprite texel map.
package box_rom_arbiter_pkg;

  localparam int unsigned SPRITE_DIM = 32;
  localparam int unsigned SPRITE_AW  = 5;
  localparam int unsigned COLOR_W    = 12;

  localparam logic [COLOR_W-1:0] COLOR_KEY     = 12'hF0F;
  localparam logic [COLOR_W-1:0] OUTLINE_COLOR = 12'h333;

  typedef logic [COLOR_W-1:0] color_t;

  typedef struct packed {
    logic [SPRITE_AW-1:0] row;
    logic [SPRITE_AW-1:0] col;
  } texel_addr_t;

  // Box sprite: transparent outer ring, dark outline ring, shaded interior.
  function automatic color_t box_texel(input texel_addr_t a);
    logic [SPRITE_AW-1:0] lo_edge;
    logic [SPRITE_AW-1:0] hi_edge;
    lo_edge = SPRITE_AW'(SPRITE_DIM - 1);
    hi_edge = SPRITE_AW'(SPRITE_DIM - 2);
    if (a.row == '0 || a.col == '0 || a.row == lo_edge || a.col == lo_edge) begin
      return COLOR_KEY;
    end else if (a.row == SPRITE_AW'(1) || a.col == SPRITE_AW'(1) ||
                 a.row == hi_edge || a.col == hi_edge) begin
      return OUTLINE_COLOR;
    end else begin
      return {a.row[SPRITE_AW-1:1], a.col[SPRITE_AW-1:1], 4'h8};
    end
  endfunction

endpackage

// File: rtl/box_rom.sv
// Box sprite ROM: address registered on clk, texel decoded from the registered address.
module box_rom
  import box_rom_arbiter_pkg::*;
(
  input  logic                 clk,
  input  logic [SPRITE_AW-1:0] row,
  input  logic [SPRITE_AW-1:0] col,
  output logic [COLOR_W-1:0]   color_data
);

  texel_addr_t addr_q;

  always_ff @(posedge clk) begin
    addr_q.row <= row;
    addr_q.col <= col;
  end

  assign color_data = box_texel(addr_q);

endmodule

// File: rtl/box_rom_arbiter.sv
// Shares one box_rom among NUM_REQ requesters: requester 0 fixed priority,
// the rest round-robin, with a starvation counter bounding requester 0's run.
module box_rom_arbiter
  import box_rom_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned STARVE_MAX = 64
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [SPRITE_AW*NUM_REQ-1:0]   req_row,
  input  logic [SPRITE_AW*NUM_REQ-1:0]   req_col,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic [NUM_REQ-1:0]             rsp_valid,
  output logic [COLOR_W-1:0]             rsp_color,
  output logic                           rsp_transparent
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);
  localparam int unsigned CNT_W = $clog2(STARVE_MAX + 1);

  logic [IDX_W-1:0]   rr_ptr;
  logic [CNT_W-1:0]   starve_cnt;
  logic               others_valid;
  logic               rr_found;
  logic [IDX_W-1:0]   rr_idx;
  logic               grant0;
  logic               grant_rr;
  logic [NUM_REQ-1:0] grant;
  logic [NUM_REQ-1:0] tag_q;
  texel_addr_t        last_addr;
  texel_addr_t        rom_addr;
  color_t             rom_color;

  assign others_valid = |req_valid[NUM_REQ-1:1];

  // Find first valid requester in 1..NUM_REQ-1 starting at rr_ptr, wrapping to 1.
  always_comb begin
    int unsigned cand;
    rr_found = 1'b0;
    rr_idx   = rr_ptr;
    cand     = 0;
    for (int unsigned k = 0; k < NUM_REQ - 1; k++) begin
      cand = 32'(rr_ptr) + k;
      if (cand >= NUM_REQ) cand = cand - (NUM_REQ - 1);
      if (!rr_found && req_valid[IDX_W'(cand)]) begin
        rr_found = 1'b1;
        rr_idx   = IDX_W'(cand);
      end
    end
  end

  // Grant decision depends only on valids, rr_ptr and the starvation counter.
  always_comb begin
    grant    = '0;
    grant0   = 1'b0;
    grant_rr = 1'b0;
    if (!reset) begin
      if (req_valid[0] && (starve_cnt < CNT_W'(STARVE_MAX) || !others_valid)) begin
        grant0   = 1'b1;
        grant[0] = 1'b1;
      end else if (rr_found) begin
        grant_rr       = 1'b1;
        grant[rr_idx]  = 1'b1;
      end
    end
  end

  assign req_ready = grant;

  // Granted texel address; held from the last grant when idle.
  always_comb begin
    rom_addr = last_addr;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        rom_addr.row = req_row[SPRITE_AW*i +: SPRITE_AW];
        rom_addr.col = req_col[SPRITE_AW*i +: SPRITE_AW];
      end
    end
  end

  box_rom u_box_rom (
    .clk        (clk),
    .row        (rom_addr.row),
    .col        (rom_addr.col),
    .color_data (rom_color)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr          <= IDX_W'(1);
      starve_cnt      <= '0;
      last_addr       <= '0;
      tag_q           <= '0;
      rsp_valid       <= '0;
      rsp_color       <= '0;
      rsp_transparent <= 1'b0;
    end else begin
      last_addr       <= rom_addr;
      tag_q           <= grant;
      rsp_valid       <= tag_q;
      rsp_color       <= rom_color;
      rsp_transparent <= (rom_color == COLOR_KEY);

      if (grant_rr) begin
        rr_ptr <= (rr_idx == IDX_W'(NUM_REQ - 1)) ? IDX_W'(1) : rr_idx + 1'b1;
      end

      // Counter measures requester 0's run while someone else is waiting.
      if (grant_rr || !others_valid) begin
        starve_cnt <= '0;
      end else if (grant0 && starve_cnt != CNT_W'(STARVE_MAX)) begin
        starve_cnt <= starve_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_box_rom_arbiter.sv
// Self-checking bench for box_rom_arbiter: directed scenarios plus random traffic
// against a behavioural grant/response model.
module tb_box_rom_arbiter;

  localparam int N  = 4;
  localparam int SM = 4;

  logic        clk;
  logic        reset;
  logic [3:0]  req_valid;
  logic [19:0] req_row;
  logic [19:0] req_col;
  logic [3:0]  req_ready;
  logic [3:0]  rsp_valid;
  logic [11:0] rsp_color;
  logic        rsp_transparent;

  box_rom_arbiter #(.NUM_REQ(N), .STARVE_MAX(SM)) dut (
    .clk             (clk),
    .reset           (reset),
    .req_valid       (req_valid),
    .req_row         (req_row),
    .req_col         (req_col),
    .req_ready       (req_ready),
    .rsp_valid       (rsp_valid),
    .rsp_color       (rsp_color),
    .rsp_transparent (rsp_transparent)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_cmp = 0;
  int n_bad = 0;

  // Model state
  int          m_ptr = 1;
  int          m_cnt = 0;
  logic [3:0]  p_tag = '0;
  logic [11:0] p_color = '0;
  logic [3:0]  last_g = '0;

  // Traffic statistics for the random phase
  bit stats_on = 1'b0;
  int gcnt[N];
  int rcnt[N];
  int waitc[N];
  int max_wait = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Distance from the nearest sprite edge selects key / outline / interior shade.
  function automatic logic [11:0] ref_texel(input int r, input int c);
    int ring;
    ring = r;
    if (c < ring) ring = c;
    if (31 - r < ring) ring = 31 - r;
    if (31 - c < ring) ring = 31 - c;
    if (ring == 0) return 12'hF0F;
    if (ring == 1) return 12'h333;
    return {4'(r / 2), 4'(c / 2), 4'h8};
  endfunction

  function automatic int model_pick(input logic [3:0] v);
    bit others;
    int i;
    others = |v[3:1];
    if (v[0] && (m_cnt < SM || !others)) return 0;
    for (int k = 0; k < N - 1; k++) begin
      i = 1 + ((m_ptr - 1 + k) % (N - 1));
      if (v[i]) return i;
    end
    return -1;
  endfunction

  // One cycle: drive at posedge+1, check grant mid-cycle, check responses after the edge.
  task automatic step(input bit rst_in, input logic [3:0] v, input logic [19:0] rows,
                      input logic [19:0] cols, input bit lit_on, input logic [3:0] lit);
    int          pick;
    logic [3:0]  g;
    logic [3:0]  exp_tag;
    logic [11:0] exp_col;
    bit          others;
    reset     = rst_in;
    req_valid = v;
    req_row   = rows;
    req_col   = cols;
    #3;
    others = |v[3:1];
    pick   = rst_in ? -1 : model_pick(v);
    g      = (pick < 0) ? 4'b0 : 4'(1 << pick);
    check("req_ready", 32'(req_ready), 32'(g));
    if (lit_on) check("grant_seq", 32'(req_ready), 32'(lit));
    last_g = g;

    if (stats_on) begin
      for (int i = 0; i < N; i++) begin
        if (req_ready[i]) gcnt[i]++;
        if (i > 0) begin
          if (v[i] && !req_ready[i]) waitc[i]++;
          else waitc[i] = 0;
          if (waitc[i] > max_wait) max_wait = waitc[i];
        end
      end
    end

    if (rst_in) begin
      m_ptr = 1;
      m_cnt = 0;
    end else begin
      if (pick == 0 && others) m_cnt = (m_cnt < SM) ? m_cnt + 1 : SM;
      if (pick > 0 || !others) m_cnt = 0;
      if (pick > 0) m_ptr = 1 + (pick % (N - 1));
    end

    exp_tag = rst_in ? 4'b0 : p_tag;
    exp_col = p_color;
    if (rst_in) begin
      p_tag = '0;
    end else begin
      p_tag = g;
      if (pick >= 0) p_color = ref_texel(int'(rows[5*pick +: 5]), int'(cols[5*pick +: 5]));
    end

    @(posedge clk);
    #1;
    check("rsp_valid", 32'(rsp_valid), 32'(exp_tag));
    if (exp_tag != 4'b0) begin
      check("rsp_color", 32'(rsp_color), 32'(exp_col));
      check("rsp_transparent", 32'(rsp_transparent), 32'(exp_col == 12'hF0F));
    end
    if (stats_on) begin
      for (int i = 0; i < N; i++) if (rsp_valid[i]) rcnt[i]++;
    end
  endtask

  function automatic logic [19:0] rnd20();
    return 20'($urandom);
  endfunction

  int seq_all[15] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 2, 0, 0, 0, 0, 3};
  int seq_rr[6]   = '{1, 2, 3, 1, 2, 3};

  initial begin
    logic [3:0] v;
    reset     = 1'b1;
    req_valid = '0;
    req_row   = '0;
    req_col   = '0;
    for (int i = 0; i < N; i++) begin
      gcnt[i] = 0;
      rcnt[i] = 0;
      waitc[i] = 0;
    end
    @(posedge clk);
    #1;

    // Reset state: nothing granted or returned even with every requester valid
    step(1'b1, 4'b1111, rnd20(), rnd20(), 1'b1, 4'b0000);
    step(1'b1, 4'b1111, rnd20(), rnd20(), 1'b1, 4'b0000);

    // Requester 0 alone at texel (0,0): key colour, transparent
    for (int k = 0; k < 4; k++) step(1'b0, 4'b0001, 20'h0, 20'h0, 1'b1, 4'b0001);
    step(1'b0, 4'b0000, rnd20(), rnd20(), 1'b1, 4'b0000);
    step(1'b0, 4'b0000, rnd20(), rnd20(), 1'b1, 4'b0000);

    // Requesters 1..3 continuously valid: plain rotation
    for (int k = 0; k < 6; k++) step(1'b0, 4'b1110, rnd20(), rnd20(), 1'b1, 4'(1 << seq_rr[k]));

    // Everyone valid: four requester-0 grants then one round-robin grant
    for (int k = 0; k < 15; k++) step(1'b0, 4'b1111, rnd20(), rnd20(), 1'b1, 4'(1 << seq_all[k]));

    // Short requester-2 pulse under requester 0 leaves rr_ptr at 1
    step(1'b1, 4'b0000, rnd20(), rnd20(), 1'b0, 4'b0000);
    step(1'b0, 4'b0101, rnd20(), rnd20(), 1'b1, 4'b0001);
    step(1'b0, 4'b0110, rnd20(), rnd20(), 1'b1, 4'b0010);

    // Reset one cycle after a grant to 1 drops the response and restores rr_ptr
    step(1'b0, 4'b0010, rnd20(), rnd20(), 1'b1, 4'b0010);
    step(1'b1, 4'b0000, rnd20(), rnd20(), 1'b1, 4'b0000);
    step(1'b1, 4'b0000, rnd20(), rnd20(), 1'b1, 4'b0000);
    step(1'b0, 4'b1010, rnd20(), rnd20(), 1'b1, 4'b0010);
    step(1'b0, 4'b0000, rnd20(), rnd20(), 1'b0, 4'b0000);
    step(1'b0, 4'b0000, rnd20(), rnd20(), 1'b0, 4'b0000);

    // Random traffic; waiting requesters tend to persist until granted
    stats_on = 1'b1;
    v = '0;
    for (int k = 0; k < 10000; k++) begin
      for (int i = 0; i < N; i++) begin
        if (v[i] && !last_g[i]) v[i] = ($urandom_range(0, 9) != 0);
        else if (i == 0) v[i] = ($urandom_range(0, 9) < 7);
        else v[i] = ($urandom_range(0, 9) < 4);
      end
      step(1'b0, v, rnd20(), rnd20(), 1'b0, 4'b0000);
    end
    step(1'b0, 4'b0000, rnd20(), rnd20(), 1'b0, 4'b0000);
    step(1'b0, 4'b0000, rnd20(), rnd20(), 1'b0, 4'b0000);
    stats_on = 1'b0;

    for (int i = 0; i < N; i++) check($sformatf("rsp_count_%0d", i), 32'(rcnt[i]), 32'(gcnt[i]));
    // Each other round-robin grant ahead can be preceded by at most SM requester-0 grants
    check("max_wait_bound", 32'(max_wait <= (N - 1) * (SM + 1)), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
